// File: rtl/ring_arbiter.sv
// Round-robin arbiter granting ring-transmit access to one port at a time,
// with a per-tenure hold limit and a drain gap between consecutive owners.
`timescale 1ns/1ps

module ring_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 255,
  parameter int GAP_CYC   = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_PORTS-1:0]         rarb_req,
  input  logic [NUM_PORTS-1:0]         port_en,
  output logic [NUM_PORTS-1:0]         rarb_ack,
  output logic                         grant_vld,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         arb_timeout,
  output logic [1:0]                   arb_state
);

  localparam int IDW = $clog2(NUM_PORTS);
  localparam int HCW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Handshake: rarb_req is a level held for the whole frame; rarb_ack rises
  // one cycle after an accepted request and falls one cycle after the request
  // (masked by port_en) drops or the hold limit is reached.

  logic [1:0]           state;
  logic [IDW-1:0]       last;
  logic [HCW-1:0]       hold_cnt;
  logic [3:0]           gap_cnt;

  logic [NUM_PORTS-1:0] eff_req;
  logic                 pick_found;
  logic [IDW-1:0]       pick_id;
  logic [IDW:0]         scan_idx;
  logic [NUM_PORTS-1:0] pick_onehot;
  logic                 own_req;
  logic                 hold_expired;

  assign eff_req      = rarb_req & port_en;
  assign own_req      = eff_req[grant_id];
  assign hold_expired = (hold_cnt == HCW'(MAX_HOLD - 1));
  assign pick_onehot  = NUM_PORTS'(1) << pick_id;
  assign arb_state    = state;

  // Scan upward from the port after the last winner, wrapping at NUM_PORTS.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      scan_idx = {1'b0, last} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NUM_PORTS)) begin
        scan_idx = scan_idx - (IDW+1)'(NUM_PORTS);
      end
      if (!pick_found && eff_req[scan_idx[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rarb_ack    <= '0;
      grant_vld   <= 1'b0;
      grant_id    <= '0;
      arb_timeout <= 1'b0;
      last        <= IDW'(NUM_PORTS - 1);
      hold_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      arb_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state     <= ST_GRANT;
            rarb_ack  <= pick_onehot;
            grant_vld <= 1'b1;
            grant_id  <= pick_id;
            last      <= pick_id;
            hold_cnt  <= '0;
          end
        end
        ST_GRANT: begin
          if (hold_cnt != HCW'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
          if (!own_req || hold_expired) begin
            rarb_ack    <= '0;
            grant_vld   <= 1'b0;
            // A drop in the expiry cycle is an ordinary release, not a timeout.
            arb_timeout <= own_req;
            if (GAP_CYC > 0) begin
              gap_cnt <= 4'(GAP_CYC - 1);
              state   <= ST_GAP;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rarb_ack  <= '0;
          grant_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ring_arbiter.md
# ring_arbiter

Round-robin arbiter for ring-transmit access among the `NUM_PORTS` port macros of the bridge. Each port raises `rarb_req[i]` when it needs to insert a frame onto the port ring. The arbiter grants exactly one port at a time via `rarb_ack[i]`, and bounds each tenure with a hold timer. Between tenures it enforces a drain gap so ring words from consecutive owners never abut.

## Interface
- `NUM_PORTS`, default 4: number of requesting ports, range 2..16.
- `MAX_HOLD`, default 255: maximum grant tenure in cycles, range 1..65535.
- `GAP_CYC`, default 1: idle cycles after a grant ends, before the next grant; range 0..15.
- `clk`  in  1  single clock for the whole block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rarb_req`  in  NUM_PORTS  per-port request; level, held for the whole frame.
- `port_en`  in  NUM_PORTS  per-port enable; a request from a disabled port is ignored.
- `rarb_ack`  out  NUM_PORTS  per-port grant; registered, one-hot or zero.
- `grant_vld`  out  1  registered; equals OR of `rarb_ack`.
- `grant_id`  out  $clog2(NUM_PORTS)  registered; index of the current or last grantee.
- `arb_timeout`  out  1  registered one-cycle pulse when a tenure is cut by `MAX_HOLD`.

## Operation
- Effective request: `eff_req = rarb_req & port_en`.
- The arbiter has three states:
  - IDLE: no grant is outstanding.
  - GRANT: one port holds `rarb_ack`.
  - GAP: drain period after a grant ends.
- IDLE:
  - If `eff_req` is nonzero, pick the first set bit scanning upward from `last+1` mod `NUM_PORTS`.
  - Load `rarb_ack` with the one-hot value of the winner, set `grant_id` to the winner, set `last` to the winner, clear `hold_cnt`, and go to GRANT.
  - If `eff_req` is zero, stay in IDLE.
- GRANT:
  - Each cycle, `hold_cnt` increments and saturates at `MAX_HOLD`.
  - Release occurs when the granted bit of `eff_req` is 0, or when `hold_cnt == MAX_HOLD-1`, meaning the grant has been visible for `MAX_HOLD` cycles.
  - On release, clear `rarb_ack`. If `GAP_CYC > 0`, load `gap_cnt = GAP_CYC-1` and go to GAP; otherwise go to IDLE.
  - A release caused by the timer pulses `arb_timeout`.
  - If the request drop and the timer expiry occur in the same cycle, the release counts as a normal release and no `arb_timeout` pulse is generated.
- GAP: decrement `gap_cnt`; when it is 0, go to IDLE. Requests are ignored during GAP.
- Fairness:
  - A timed-out port keeps its request, but `last` now points at it, so every other requester is served first.
  - A port that is the sole requester is re-granted after the gap.
- `port_en` cleared for the grantee during GRANT is treated as a request drop: ack is released at the next edge.
- `hold_cnt` width is $clog2(`MAX_HOLD`+1). `gap_cnt` is 4 bits.
- Reset values: state = IDLE, `rarb_ack` = 0, `grant_vld` = 0, `grant_id` = 0, `arb_timeout` = 0, `last` = `NUM_PORTS`-1 (so port 0 wins first), both counters = 0.
- Asserting `reset_n` during GRANT drops `rarb_ack` asynchronously. The ports must abort any partial insertion on their own.

## Timing
- Request to ack: `eff_req` sampled high in IDLE at edge N gives `rarb_ack` high after edge N. Latency is one cycle.
- Request drop to ack drop: `rarb_req` sampled low at edge M gives `rarb_ack` low after edge M, one cycle.
- Maximum tenure: `rarb_ack` is high for exactly `MAX_HOLD` cycles.
- Back-to-back grants: the ack-low gap is `GAP_CYC`+1 cycles. The "+1" is the IDLE arbitration cycle.
- `arb_timeout` is high in the same cycle `rarb_ack` first reads 0.
- No combinational path from any input to any output.
- Invariant: at most one bit of `rarb_ack` is set.

## Test plan
- Reset, then port 2 requests alone with `GAP_CYC`=1: ack[2] one cycle later; hold for 10 cycles; drop req; ack low next cycle; `grant_vld` low; `grant_id`=2.
- All 4 ports request continuously, `MAX_HOLD`=8: grant order 0,1,2,3,0,…; each ack is high 8 cycles; `arb_timeout` pulses once per tenure; ack gap is 2 cycles.
- Ports 1 and 3 request, port 1 drops after 3 cycles: port 3 is granted after the gap. Then port 1 re-requests while port 3 holds: port 1 waits until port 3 releases.
- `port_en[0]`=0 while port 0 requests: port 0 is never granted. Clear `port_en[1]` during port 1's grant: ack[1] drops next cycle with no `arb_timeout`.
- Request drop coinciding with timer expiry (drop in cycle `MAX_HOLD`): ack releases and `arb_timeout` stays 0.
- Assert `reset_n` mid-grant: `rarb_ack` goes 0 immediately. After release, port 0 (with all ports requesting) is the first grantee.
